// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, grant owner
// encoding and the width of the fetch-starvation counter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_IF,
    GRANT_DM,
    RESP_IF,
    RESP_DM
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch waits;
// sat tells the arbiter that the next grant must go to fetch.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_CNT_W-1:0] cnt;

  assign sat = (cnt == STARVE_CNT_W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// sequencing each access over the req/ack backend and stalling the owning stage.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t state;
  arb_state_t state_nxt;
  owner_t     next_owner;
  logic       starve_sat;
  logic       grant_dm_entry;
  logic       grant_if_entry;

  // Data normally wins a collision; a saturated counter hands the slot to fetch.
  always_comb begin
    next_owner = OWN_IF;
    if (dm_req && (!if_req || !starve_sat)) begin
      next_owner = OWN_DM;
    end
  end

  assign grant_dm_entry = (state == IDLE) && dm_req && (next_owner == OWN_DM);
  assign grant_if_entry = (state == IDLE) && if_req && (next_owner == OWN_IF);

  mem_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk(clk),
    .rst(rst),
    .inc(grant_dm_entry && if_req),
    .clr(grant_if_entry || !if_req),
    .sat(starve_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm_entry) begin
          state_nxt = GRANT_DM;
        end else if (grant_if_entry) begin
          state_nxt = GRANT_IF;
        end
      end
      GRANT_IF: if (mem_ack) state_nxt = RESP_IF;
      GRANT_DM: if (mem_ack) state_nxt = RESP_DM;
      RESP_IF:  state_nxt = IDLE;
      RESP_DM:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A dropped request (flush) suppresses the ready pulse for its own access.
  always_comb begin
    if_ready  = (state == RESP_IF) && if_req;
    dm_ready  = (state == RESP_DM) && dm_req;
    stall_if  = if_req && !if_ready;
    stall_mem = dm_req && !dm_ready;
  end

  // Backend side is fully registered; read data is kept only for a live read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm_entry) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_if_entry) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        GRANT_IF: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (if_req) begin
              if_rdata <= mem_rdata;
            end
          end
        end
        GRANT_DM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (dm_req && !mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized accesses, all checked against a word-addressed reference memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;

  int   compared     = 0;
  int   mismatched   = 0;
  int   if_ready_cnt = 0;
  int   dm_ready_cnt = 0;
  int   ack_lat      = 1;
  int   bk_cnt       = 0;
  logic ack_bk       = 1'b0;
  logic ack_force    = 1'b0;
  bit   rec_grants   = 1'b0;
  logic [7:0] grant_seq = '0;
  int   grant_cnt    = 0;
  logic mem_req_q    = 1'b0;

  logic [31:0] bk_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  assign mem_ack = ack_bk | ack_force;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_ready(dm_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .stall_if(stall_if),
    .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bk_read(input logic [31:0] a);
    if (bk_mem.exists(a)) return bk_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    if_req   = ireq;
    if_addr  = iaddr;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Ticks until the chosen port reports ready; -1 marks an expired budget.
  task automatic wait_ready(input bit want_if, input int max_cycles, output int n);
    n = 0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      n++;
      if ((want_if && if_ready) || (!want_if && dm_ready)) return;
    end
    n = -1;
  endtask

  // Backend memory: acks ack_lat cycles after mem_req rises, commits writes at ack.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      bk_cnt = 0;
      ack_bk = 1'b0;
    end else if (!ack_bk) begin
      bk_cnt++;
      if (bk_cnt >= ack_lat) begin
        ack_bk = 1'b1;
        if (mem_we) begin
          bk_mem[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = bk_read(mem_addr);
        end
      end
    end else begin
      ack_bk = 1'b0;
      bk_cnt = 0;
    end
  end

  // Every ready pulse is counted and its read data compared with the reference.
  always @(posedge clk) begin
    #1;
    if (if_ready) begin
      if_ready_cnt++;
      checkOutput("if_rdata", if_rdata, ref_read(if_addr));
    end
    if (dm_ready) begin
      dm_ready_cnt++;
      if (dm_we) ref_mem[dm_addr] = dm_wdata;
      else checkOutput("dm_rdata", dm_rdata, ref_read(dm_addr));
    end
    if (rec_grants && mem_req && !mem_req_q) begin
      grant_seq = {grant_seq[6:0], (mem_addr >= 32'h2000)};
      grant_cnt++;
    end
    mem_req_q = mem_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int n2;
    int d_left;
    int if_base;
    int dm_base;
    int exp_if;
    int exp_dm;

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_dm_rdata", dm_rdata, 0);
    checkOutput("rst_ready", {if_ready, dm_ready}, 0);
    checkOutput("rst_stall", {stall_if, stall_mem}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, ack two cycles after mem_req.
    bk_mem[32'h40]  = 32'h2010_0005;
    ref_mem[32'h40] = 32'h2010_0005;
    ack_lat = 2;
    applyStimulus(1, 32'h40, 0, 0, 0, 0);
    checkOutput("fetch_stall_before", stall_if, 1);
    tick();
    checkOutput("fetch_mem_req", mem_req, 1);
    checkOutput("fetch_mem_addr", mem_addr, 32'h40);
    checkOutput("fetch_mem_we", mem_we, 0);
    wait_ready(1, 20, n);
    checkOutput("fetch_latency", (n < 0) ? -1 : n + 1, ack_lat + 1);
    checkOutput("fetch_if_rdata", if_rdata, 32'h2010_0005);
    checkOutput("fetch_stall_at_ready", stall_if, 0);
    applyStimulus(0, 32'h40, 0, 0, 0, 0);
    tick();
    checkOutput("fetch_single_pulse", if_ready, 0);
    checkOutput("fetch_ready_count", if_ready_cnt, 1);

    // Collision: data read first, then fetch, each exactly once.
    ack_lat = 1;
    applyStimulus(1, 32'h48, 1, 0, 32'h100, 0);
    wait_ready(0, 20, n);
    checkOutput("collide_dm_latency", n, ack_lat + 1);
    checkOutput("collide_if_waiting", stall_if, 1);
    applyStimulus(1, 32'h48, 0, 0, 32'h100, 0);
    wait_ready(1, 20, n2);
    checkOutput("collide_if_latency", n2, ack_lat + 2);
    applyStimulus(0, 32'h48, 0, 0, 32'h100, 0);
    tick();
    tick();
    checkOutput("collide_if_count", if_ready_cnt, 2);
    checkOutput("collide_dm_count", dm_ready_cnt, 1);

    // Starvation: data keeps requesting while fetch waits.
    rec_grants = 1'b1;
    grant_seq  = '0;
    grant_cnt  = 0;
    d_left     = 5;
    applyStimulus(1, 32'h1000, 1, 0, 32'h2000, 0);
    for (int c = 0; c < 200 && (if_req || dm_req); c++) begin
      tick();
      if (dm_ready) begin
        d_left--;
        if (d_left > 0) dm_addr = dm_addr + 32'h4;
        else dm_req = 1'b0;
      end
      if (if_ready) if_req = 1'b0;
    end
    tick();
    rec_grants = 1'b0;
    checkOutput("starve_done", {if_req, dm_req}, 0);
    checkOutput("starve_grant_cnt", grant_cnt, 6);
    checkOutput("starve_grant_order", grant_seq, 8'b0011_1101);

    // Write with a stable backend view, then read it back.
    ack_lat = 2;
    applyStimulus(0, 0, 1, 1, 32'h8, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_mem_we", mem_we, 1);
    checkOutput("wr_mem_addr", mem_addr, 32'h8);
    checkOutput("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_hold", {mem_req, mem_we, mem_addr[7:0]}, {1'b1, 1'b1, 8'h08});
    checkOutput("wr_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    dm_base = dm_ready_cnt;
    wait_ready(0, 20, n);
    checkOutput("wr_latency", (n < 0) ? -1 : n + 2, ack_lat + 1);
    applyStimulus(0, 0, 0, 1, 32'h8, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_single_pulse", dm_ready_cnt, dm_base + 1);
    applyStimulus(0, 0, 1, 0, 32'h8, 0);
    wait_ready(0, 20, n);
    checkOutput("wr_readback", dm_rdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 32'h8, 0);
    tick();

    // Flush: fetch drops one cycle into its grant; backend still completes.
    ack_lat = 4;
    if_base = if_ready_cnt;
    applyStimulus(1, 32'h80, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 32'h80, 0, 0, 0, 0);
    checkOutput("flush_stall", stall_if, 0);
    for (int c = 0; c < 20 && mem_req; c++) tick();
    tick();
    tick();
    checkOutput("flush_mem_req", mem_req, 0);
    checkOutput("flush_no_ready", if_ready_cnt, if_base);
    ack_lat = 1;
    applyStimulus(1, 32'h44, 0, 0, 0, 0);
    wait_ready(1, 20, n);
    checkOutput("flush_next_latency", n, ack_lat + 1);
    applyStimulus(0, 32'h44, 0, 0, 0, 0);
    tick();

    // Reset in the middle of a data grant, then a stray ack.
    ack_lat = 5;
    applyStimulus(0, 0, 1, 0, 32'h30, 0);
    tick();
    tick();
    checkOutput("rstmid_mem_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_mem_req_now", mem_req, 0);
    checkOutput("rstmid_dm_rdata", dm_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    if_base = if_ready_cnt;
    dm_base = dm_ready_cnt;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    tick();
    tick();
    checkOutput("late_ack_mem_req", mem_req, 0);
    checkOutput("late_ack_no_ready", {16'(if_ready_cnt - if_base), 16'(dm_ready_cnt - dm_base)}, 0);
    ack_lat = 1;
    applyStimulus(1, 32'h4, 0, 0, 0, 0);
    wait_ready(1, 20, n);
    checkOutput("late_ack_idle_latency", n, ack_lat + 1);
    applyStimulus(0, 32'h4, 0, 0, 0, 0);
    tick();

    // Randomized mix of fetches, reads and writes over a small address window.
    if_base = if_ready_cnt;
    dm_base = dm_ready_cnt;
    exp_if  = 0;
    exp_dm  = 0;
    for (int it = 0; it < 40; it++) begin
      int kind;
      int first;
      kind    = $urandom_range(0, 2);
      ack_lat = $urandom_range(1, 4);
      if (kind != 1) exp_if++;
      if (kind != 0) exp_dm++;
      applyStimulus(kind != 1, 32'($urandom_range(0, 15)) << 2,
                    kind != 0, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 15)) << 2, $urandom);
      n = 0;
      first = 0;
      for (int c = 0; c < 60 && (if_req || dm_req); c++) begin
        tick();
        n++;
        if (if_ready) begin
          if (first == 0) first = n;
          if_req = 1'b0;
        end
        if (dm_ready) begin
          if (first == 0) first = n;
          dm_req = 1'b0;
        end
      end
      checkOutput("rnd_done", {if_req, dm_req}, 0);
      if (kind != 2) checkOutput("rnd_latency", first, ack_lat + 1);
      tick();
    end
    checkOutput("rnd_if_count", if_ready_cnt - if_base, exp_if);
    checkOutput("rnd_dm_count", dm_ready_cnt - dm_base, exp_dm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
